// File: rtl/pixel_stream_reader.sv
// Pops pixels from a registered-read FIFO through a 2-entry skid buffer and
// emits them as a valid/ready stream tagged with column/row and frame markers.
module pixel_stream_reader #(
  parameter int DW    = 8,
  parameter int IMG_W = 512,
  parameter int IMG_H = 512
) (
  input  logic          CLK,
  input  logic          RST,
  output logic          o_rden,
  input  logic [DW-1:0] i_fifo_data,
  input  logic          i_fifo_empty,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_pixel,
  output logic [11:0]   o_col,
  output logic [11:0]   o_row,
  output logic          o_sol,
  output logic          o_eol,
  output logic          o_sof,
  output logic          o_eof
);

  localparam logic [11:0] COL_LAST = 12'(IMG_W - 1);
  localparam logic [11:0] ROW_LAST = 12'(IMG_H - 1);

  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] tail_q, tail_d;
  logic [1:0]    occ_q, occ_d;
  logic          inflight_q, inflight_d;
  logic [11:0]   col_q, col_d;
  logic [11:0]   row_q, row_d;

  logic [1:0]    pending;
  logic          xfer;

  // Read issue: slots already committed (buffered + in flight) must leave room
  // for the returning word, counting a pop that happens this same cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    pending = occ_q + {1'b0, inflight_q};
    xfer    = (occ_q != 2'd0) && i_ready;
    o_rden  = 1'b0;
    if (RST && !i_fifo_empty) begin
      o_rden = (pending < 2'd2) || ((pending == 2'd2) && xfer);
    end
  end

  // Skid buffer: head is the output word, tail holds the second entry.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    occ_d      = occ_q;
    inflight_d = o_rden;
    unique case ({xfer, inflight_q})
      2'b10: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b01: begin
        if (occ_q == 2'd0) head_d = i_fifo_data;
        else               tail_d = i_fifo_data;
        occ_d = occ_q + 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_d = i_fifo_data;
        end else begin
          head_d = tail_q;
          tail_d = i_fifo_data;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (xfer) begin
      if (col_q == COL_LAST) begin
        col_d = 12'd0;
        row_d = (row_q == ROW_LAST) ? 12'd0 : row_q + 12'd1;
      end else begin
        col_d = col_q + 12'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      col_q      <= 12'd0;
      row_q      <= 12'd0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      col_q      <= col_d;
      row_q      <= row_d;
    end
  end

  // NOTE: pixel storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge CLK) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

  always_comb begin
    o_valid = (occ_q != 2'd0);
    o_pixel = head_q;
    o_col   = col_q;
    o_row   = row_q;
    o_sol   = o_valid && (col_q == 12'd0);
    o_eol   = o_valid && (col_q == COL_LAST);
    o_sof   = o_valid && (col_q == 12'd0) && (row_q == 12'd0);
    o_eof   = o_valid && (col_q == COL_LAST) && (row_q == ROW_LAST);
  end

endmodule

// File: tb/tb_pixel_stream_reader.sv
// Bench for pixel_stream_reader: a FIFO model with registered read data, a
// transaction-level scoreboard, a frame-marker table and directed corner cases.
module tb_pixel_stream_reader;

  localparam int DW    = 8;
  localparam int IMG_W = 4;
  localparam int IMG_H = 2;

  logic          CLK;
  logic          RST;
  logic          o_rden;
  logic [DW-1:0] fifo_data;
  logic          i_fifo_empty;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_pixel;
  logic [11:0]   o_col;
  logic [11:0]   o_row;
  logic          o_sol, o_eol, o_sof, o_eof;

  pixel_stream_reader #(.DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .o_rden       (o_rden),
    .i_fifo_data  (fifo_data),
    .i_fifo_empty (i_fifo_empty),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_pixel      (o_pixel),
    .o_col        (o_col),
    .o_row        (o_row),
    .o_sol        (o_sol),
    .o_eol        (o_eol),
    .o_sof        (o_sof),
    .o_eof        (o_eof)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO model: preloaded array, registered read data one cycle after o_rden.
  logic [7:0] mem [0:4095];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       force_empty;
  assign i_fifo_empty = force_empty || (rd_ptr == wr_ptr);

  // Scoreboard: pixels popped from the FIFO, in order, awaiting transfer.
  logic       mon_en;
  logic [7:0] exp_q[$];
  int         outst = 0;
  int         xfer_cnt = 0;
  logic       inflight_m = 1'b0;
  logic       rden_s = 1'b0, xfer_s = 1'b0, rst_s = 1'b0;
  int         m_occ, m_pos, m_col, m_row;
  logic       m_valid, m_xfer, m_rden;

  always @(negedge CLK) begin
    rden_s = o_rden;
    rst_s  = RST;
    xfer_s = 1'b0;
    if (mon_en) begin
      m_occ   = outst - int'(inflight_m);
      m_valid = (m_occ > 0);
      m_xfer  = m_valid && i_ready;
      m_rden  = RST && !i_fifo_empty && ((outst < 2) || ((outst == 2) && m_xfer));
      check("rden_rule", 32'(o_rden), 32'(m_rden));
      check("valid", 32'(o_valid), 32'(m_valid));
      if (m_valid && exp_q.size() > 0) begin
        m_pos = xfer_cnt % (IMG_W * IMG_H);
        m_col = m_pos % IMG_W;
        m_row = m_pos / IMG_W;
        check("pixel", 32'(o_pixel), 32'(exp_q[0]));
        check("col", 32'(o_col), 32'(m_col));
        check("row", 32'(o_row), 32'(m_row));
        check("flags", 32'({o_sol, o_eol, o_sof, o_eof}),
              32'({m_col == 0, m_col == IMG_W - 1, m_pos == 0, m_pos == IMG_W * IMG_H - 1}));
      end else if (!m_valid) begin
        check("flags_idle", 32'({o_sol, o_eol, o_sof, o_eof}), 32'd0);
      end
      xfer_s = m_xfer;
    end
  end

  always @(posedge CLK) begin
    if (mon_en) begin
      if (!rst_s) begin
        outst      = 0;
        inflight_m = 1'b0;
        xfer_cnt   = 0;
        exp_q.delete();
      end else begin
        if (xfer_s && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          xfer_cnt++;
        end
        if (rden_s) exp_q.push_back(mem[rd_ptr]);
        outst      = outst + int'(rden_s) - int'(xfer_s);
        inflight_m = rden_s;
      end
    end
    if (rden_s) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end else begin
      fifo_data <= 8'($urandom);
    end
  end

  typedef struct {
    logic [7:0]  din;
    logic [11:0] col;
    logic [11:0] row;
    logic        sol, eol, sof, eof;
  } frame_vec_t;

  frame_vec_t tbl [16];

  task automatic push(input logic [7:0] v);
    mem[wr_ptr] = v;
    wr_ptr++;
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RST = 1'b0; i_ready = 1'b0; force_empty = 1'b0;
    @(posedge CLK);
    @(posedge CLK); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n, cyc;
    logic [7:0] nxt;

    tbl[0]  = '{8'hA0, 12'd0, 12'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{8'hA1, 12'd1, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{8'hA2, 12'd2, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{8'hA3, 12'd3, 12'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{8'hA4, 12'd0, 12'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{8'hA5, 12'd1, 12'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{8'hA6, 12'd2, 12'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{8'hA7, 12'd3, 12'd1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{8'hA8, 12'd0, 12'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{8'hA9, 12'd1, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{8'hAA, 12'd2, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{8'hAB, 12'd3, 12'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{8'hAC, 12'd0, 12'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{8'hAD, 12'd1, 12'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{8'hAE, 12'd2, 12'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{8'hAF, 12'd3, 12'd1, 1'b0, 1'b1, 1'b0, 1'b1};

    RST = 1'b0; i_ready = 1'b0; force_empty = 1'b0; mon_en = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_rden", 32'(o_rden), 32'd0);
    check("rst_col", 32'(o_col), 32'd0);
    check("rst_row", 32'(o_row), 32'd0);
    check("rst_flags", 32'({o_sol, o_eol, o_sof, o_eof}), 32'd0);
    @(posedge CLK); #1;
    mon_en = 1'b1;

    // Frame markers over two back-to-back 4x2 frames.
    for (int i = 0; i < 16; i++) push(tbl[i].din);
    i_ready = 1'b1; RST = 1'b1;
    n = 0;
    for (cyc = 0; cyc < 80 && n < 16; cyc++) begin
      @(negedge CLK);
      if (o_valid && i_ready) begin
        check("frm_pix", 32'(o_pixel), 32'(tbl[n].din));
        check("frm_col", 32'(o_col), 32'(tbl[n].col));
        check("frm_row", 32'(o_row), 32'(tbl[n].row));
        check("frm_flags", 32'({o_sol, o_eol, o_sof, o_eof}),
              32'({tbl[n].sol, tbl[n].eol, tbl[n].sof, tbl[n].eof}));
        n++;
      end
    end
    check("frm_count", 32'(n), 32'd16);

    // Streaming: latency and 256 bubble-free transfers.
    do_reset();
    for (int i = 0; i < 256; i++) push(8'(i));
    i_ready = 1'b1; RST = 1'b1;
    @(negedge CLK);
    check("lat_rden_c0", 32'(o_rden), 32'd1);
    check("lat_valid_c0", 32'(o_valid), 32'd0);
    @(negedge CLK);
    check("lat_valid_c1", 32'(o_valid), 32'd0);
    for (int i = 0; i < 256; i++) begin
      @(negedge CLK);
      check("stream_valid", 32'(o_valid), 32'd1);
      check("stream_pix", 32'(o_pixel), 32'(i));
    end

    // Random backpressure and random empty flag.
    do_reset();
    for (int i = 0; i < 120; i++) push(8'($urandom));
    RST = 1'b1;
    n = 0;
    for (cyc = 0; cyc < 3000 && n < 120; cyc++) begin
      i_ready     = 1'($urandom_range(0, 1));
      force_empty = ($urandom_range(0, 5) == 0);
      @(negedge CLK);
      if (o_valid && i_ready) n++;
      @(posedge CLK); #1;
    end
    force_empty = 1'b0;
    check("bp_count", 32'(n), 32'd120);
    check("bp_drained", 32'(rd_ptr == wr_ptr), 32'd1);

    // FIFO empty for 10 cycles mid-stream.
    do_reset();
    for (int i = 0; i < 30; i++) push(8'(8'h40 + i));
    i_ready = 1'b1; RST = 1'b1;
    n = 0;
    repeat (6) begin
      @(negedge CLK);
      if (o_valid && i_ready) n++;
      @(posedge CLK); #1;
    end
    force_empty = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("empty_rden", 32'(o_rden), 32'd0);
      if (o_valid && i_ready) n++;
      if (i < 9) begin
        @(posedge CLK); #1;
      end
    end
    check("empty_drained", 32'(o_valid), 32'd0);
    @(posedge CLK); #1;
    force_empty = 1'b0;
    for (cyc = 0; cyc < 10; cyc++) begin
      @(negedge CLK);
      if (o_valid) break;
      @(posedge CLK); #1;
    end
    check("empty_resume", 32'(o_valid), 32'd1);
    for (cyc = 0; cyc < 200 && n < 30; cyc++) begin
      if (o_valid && i_ready) n++;
      @(posedge CLK); #1;
      @(negedge CLK);
    end
    check("empty_count", 32'(n), 32'd30);

    // Reset mid-frame with a read in flight.
    do_reset();
    for (int i = 0; i < 40; i++) push(8'(8'hC0 + i));
    i_ready = 1'b1; RST = 1'b1;
    n = 0;
    for (cyc = 0; cyc < 50; cyc++) begin
      @(negedge CLK);
      if (o_valid && i_ready) n++;
      if (n == 5) break;
      @(posedge CLK); #1;
    end
    check("mid_xfers", 32'(n), 32'd5);
    check("mid_rden", 32'(o_rden), 32'd1);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK);
    check("mid_valid_after_rst", 32'(o_valid), 32'd0);
    check("mid_rden_in_rst", 32'(o_rden), 32'd0);
    @(posedge CLK); #1;
    nxt = mem[rd_ptr];
    RST = 1'b1;
    for (cyc = 0; cyc < 10; cyc++) begin
      @(negedge CLK);
      if (o_valid) break;
      @(posedge CLK); #1;
    end
    check("mid_latency", 32'(cyc), 32'd2);
    check("mid_sof", 32'(o_sof), 32'd1);
    check("mid_col", 32'(o_col), 32'd0);
    check("mid_row", 32'(o_row), 32'd0);
    check("mid_pixel", 32'(o_pixel), 32'(nxt));
    for (cyc = 0; cyc < 200; cyc++) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      if (rd_ptr == wr_ptr && !o_valid) break;
    end
    check("mid_drained", 32'(o_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
